// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single physical memory request port between the
// instruction fetch unit (IFU) and the load/store unit (LSU).
// One transaction is outstanding at a time. Simultaneous requests are
// arbitrated round-robin. A response timeout keeps a hung memory from
// stalling the core forever, and the timeout is recorded in sticky bus_err.
module mem_arbiter #(
  parameter int unsigned AW      = 64,
  parameter int unsigned DW      = 64,
  parameter int unsigned TIMEOUT = 255   // legal range 1..65535
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction fetch channel
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_resp_valid,
  output logic [DW-1:0]   ifu_resp_data,
  // load/store channel
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic            lsu_we,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_resp_valid,
  output logic [DW-1:0]   lsu_resp_data,
  // downstream memory port
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  // sticky timeout flag
  output logic            bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,   // waiting for a requester
    REQ  = 2'd1,   // request presented downstream, waiting for mem_ready
    RESP = 2'd2    // request accepted downstream, waiting for mem_rvalid
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Last wait-counter value before the timeout fires: the timeout completes
  // the transaction in the TIMEOUT-th RESP cycle without a response.
  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  // State and datapath registers
  state_e            state_q,          state_d;
  owner_e            owner_q,          owner_d;
  owner_e            last_grant_q,     last_grant_d;
  logic [15:0]       cnt_q,            cnt_d;
  logic              bus_err_q,        bus_err_d;
  logic              mem_valid_q,      mem_valid_d;
  logic              mem_we_q,         mem_we_d;
  logic [AW-1:0]     mem_addr_q,       mem_addr_d;
  logic [DW-1:0]     mem_wdata_q,      mem_wdata_d;
  logic [DW/8-1:0]   mem_wmask_q,      mem_wmask_d;
  logic              ifu_resp_valid_q, ifu_resp_valid_d;
  logic [DW-1:0]     ifu_resp_data_q,  ifu_resp_data_d;
  logic              lsu_resp_valid_q, lsu_resp_valid_d;
  logic [DW-1:0]     lsu_resp_data_q,  lsu_resp_data_d;

  // Arbitration results for the current IDLE cycle
  logic              grant_ifu;
  logic              grant_lsu;

  // Completion of the outstanding transaction in RESP
  logic              done;
  logic [DW-1:0]     done_data;

  // Round-robin winner selection; ready is only ever offered in IDLE and
  // is held low while reset is asserted.
  always_comb begin
    // NOTE: every signal driven from always_comb gets a default before any
    // branch; a path that leaves a signal unassigned infers a latch.
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      if (lsu_req_valid && (!ifu_req_valid || (last_grant_q == OWN_IFU))) begin
        grant_lsu = 1'b1;
      end else if (ifu_req_valid) begin
        grant_ifu = 1'b1;
      end
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  // Next-state, request latching and response generation
  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    last_grant_d     = last_grant_q;
    cnt_d            = cnt_q;
    bus_err_d        = bus_err_q;
    mem_valid_d      = 1'b0;
    mem_we_d         = mem_we_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    mem_wmask_d      = mem_wmask_q;
    ifu_resp_valid_d = 1'b0;
    ifu_resp_data_d  = '0;
    lsu_resp_valid_d = 1'b0;
    lsu_resp_data_d  = '0;
    done             = 1'b0;
    done_data        = '0;

    case (state_q)
      IDLE: begin
        if (grant_lsu) begin
          mem_valid_d  = 1'b1;
          mem_we_d     = lsu_we;
          mem_addr_d   = lsu_addr;
          mem_wdata_d  = lsu_wdata;
          mem_wmask_d  = lsu_wmask;
          owner_d      = OWN_LSU;
          last_grant_d = OWN_LSU;
          state_d      = REQ;
        end else if (grant_ifu) begin
          // Fetches are always reads with no byte lanes enabled.
          mem_valid_d  = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = ifu_addr;
          mem_wdata_d  = '0;
          mem_wmask_d  = '0;
          owner_d      = OWN_IFU;
          last_grant_d = OWN_IFU;
          state_d      = REQ;
        end
      end

      REQ: begin
        // Latched fields stay put; only the valid flag is decided here.
        if (mem_ready) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          mem_valid_d = 1'b1;
        end
      end

      RESP: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_rvalid) begin
          // Stores are acknowledged with zero data, whatever the memory drives.
          done      = 1'b1;
          done_data = mem_we_q ? '0 : mem_rdata;
        end else if (cnt_q == CntLast) begin
          // Forced completion: the requester gets zero data, the error sticks.
          done      = 1'b1;
          done_data = '0;
          bus_err_d = 1'b1;
        end
        if (done) begin
          state_d = IDLE;
          if (owner_q == OWN_LSU) begin
            lsu_resp_valid_d = 1'b1;
            lsu_resp_data_d  = done_data;
          end else begin
            ifu_resp_valid_d = 1'b1;
            ifu_resp_data_d  = done_data;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; asynchronous reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q          <= IDLE;
      owner_q          <= OWN_IFU;
      last_grant_q     <= OWN_IFU;
      cnt_q            <= '0;
      bus_err_q        <= 1'b0;
      mem_valid_q      <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_wmask_q      <= '0;
      ifu_resp_valid_q <= 1'b0;
      ifu_resp_data_q  <= '0;
      lsu_resp_valid_q <= 1'b0;
      lsu_resp_data_q  <= '0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      last_grant_q     <= last_grant_d;
      cnt_q            <= cnt_d;
      bus_err_q        <= bus_err_d;
      mem_valid_q      <= mem_valid_d;
      mem_we_q         <= mem_we_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      mem_wmask_q      <= mem_wmask_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      ifu_resp_data_q  <= ifu_resp_data_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      lsu_resp_data_q  <= lsu_resp_data_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_wmask      = mem_wmask_q;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_resp_data  = ifu_resp_data_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_resp_data  = lsu_resp_data_q;
  assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a small memory model
// and a response scoreboard (expected owner/data pushed on acceptance).
module tb_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ifu_req_valid, ifu_req_ready;
  logic [AW-1:0]   ifu_addr;
  logic            ifu_resp_valid;
  logic [DW-1:0]   ifu_resp_data;
  logic            lsu_req_valid, lsu_req_ready, lsu_we;
  logic [AW-1:0]   lsu_addr;
  logic [DW-1:0]   lsu_wdata;
  logic [DW/8-1:0] lsu_wmask;
  logic            lsu_resp_valid;
  logic [DW-1:0]   lsu_resp_data;
  logic            mem_valid, mem_ready, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wmask;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic            bus_err;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        owner;   // 0 = IFU, 1 = LSU
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  logic grant_log[$];
  int   resp_count = 0;
  int   last_acc_cyc = 0;
  int   last_resp_cyc = 0;

  // memory model controls, written only by the stimulus block
  logic hang = 1'b0;
  int   stall_cfg = 0;
  logic late_inject = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mdata(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h0000_0013_0000_0093;
    return {~a[31:0], a[31:0]};
  endfunction

  // Memory model: ready after stall_cfg REQ cycles, response the cycle after.
  initial begin : mem_model
    logic        pend_resp;
    logic [63:0] pend_data;
    int          stalled;
    pend_resp = 1'b0; pend_data = '0; stalled = 0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (!rst_n) begin
        pend_resp = 1'b0; stalled = 0;
      end else begin
        if (late_inject) begin
          mem_rvalid = 1'b1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
        end else if (pend_resp) begin
          pend_resp = 1'b0;
          if (!hang) begin mem_rvalid = 1'b1; mem_rdata = pend_data; end
        end
        if (mem_valid) begin
          if (stalled < stall_cfg) stalled++;
          else begin
            stalled = 0; mem_ready = 1'b1; pend_resp = 1'b1;
            pend_data = mem_we ? 64'hBAD0_BAD0_BAD0_BAD0 : mdata(mem_addr);
          end
        end
      end
    end
  end

  // Monitor: push on acceptance, pop and compare on every response pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete(); grant_log.delete();
    end else begin
      if (ifu_req_valid && ifu_req_ready) begin
        e.owner = 1'b0; e.data = hang ? 64'd0 : mdata(ifu_addr);
        sb.push_back(e); grant_log.push_back(1'b0); last_acc_cyc = cyc;
      end
      if (lsu_req_valid && lsu_req_ready) begin
        e.owner = 1'b1; e.data = (hang || lsu_we) ? 64'd0 : mdata(lsu_addr);
        sb.push_back(e); grant_log.push_back(1'b1); last_acc_cyc = cyc;
      end
      if (ifu_resp_valid || lsu_resp_valid) begin
        resp_count++; last_resp_cyc = cyc;
        check("resp_exclusive", {63'd0, ifu_resp_valid & lsu_resp_valid}, 64'd0);
        check("resp_expected", {63'd0, sb.size() > 0}, 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("resp_owner", {63'd0, lsu_resp_valid}, {63'd0, e.owner});
          check("resp_data", lsu_resp_valid ? lsu_resp_data : ifu_resp_data, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic wait_ready(input bit lsu);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      sample();
      seen = lsu ? lsu_req_ready : ifu_req_ready;
    end
    check(lsu ? "lsu_accept_wait" : "ifu_accept_wait", {63'd0, seen}, 64'd1);
  endtask

  task automatic wait_resps(input int n);
    for (int i = 0; i < 100 && resp_count < n; i++) sample();
    check("resp_wait", {63'd0, resp_count >= n}, 64'd1);
  endtask

  task automatic issue_ifu(input logic [63:0] a);
    tick(); ifu_req_valid = 1'b1; ifu_addr = a;
    wait_ready(1'b0);
    tick(); ifu_req_valid = 1'b0; ifu_addr = '0;
  endtask

  task automatic issue_lsu(input logic we, input logic [63:0] a,
                           input logic [63:0] wd, input logic [7:0] wm);
    tick(); lsu_req_valid = 1'b1; lsu_we = we; lsu_addr = a; lsu_wdata = wd; lsu_wmask = wm;
    wait_ready(1'b1);
    tick(); lsu_req_valid = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
  endtask

  initial begin : stim
    int base;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;

    // reset state
    repeat (3) tick();
    check("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_resp_valid", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    check("rst_bus_err", {63'd0, bus_err}, 64'd0);
    rst_n = 1'b1;

    // single fetch: fields while mem_valid, response exactly 3 cycles after accept
    issue_ifu(64'h8000_0000);
    sample();
    check("fetch_mem_valid", {63'd0, mem_valid}, 64'd1);
    check("fetch_mem_addr", mem_addr, 64'h8000_0000);
    check("fetch_mem_we", {63'd0, mem_we}, 64'd0);
    check("fetch_mem_wmask", {56'd0, mem_wmask}, 64'd0);
    wait_resps(1);
    check("fetch_latency", 64'(last_resp_cyc - last_acc_cyc), 64'd3);

    // store ack: exact fields, zero ack data even though memory drives garbage
    issue_lsu(1'b1, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F);
    sample();
    check("store_mem_valid", {63'd0, mem_valid}, 64'd1);
    check("store_mem_we", {63'd0, mem_we}, 64'd1);
    check("store_mem_addr", mem_addr, 64'h8000_1000);
    check("store_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
    check("store_mem_wmask", {56'd0, mem_wmask}, 64'h0F);
    wait_resps(2);

    // load through the LSU
    issue_lsu(1'b0, 64'h8000_2000, 64'd0, 8'h00);
    wait_resps(3);

    // backpressure: mem_ready low for 5 cycles while LSU waits
    tick(); stall_cfg = 5;
    issue_ifu(64'h8000_3000);
    lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_4000;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("bp_mem_valid", {63'd0, mem_valid}, 64'd1);
      check("bp_mem_addr", mem_addr, 64'h8000_3000);
      check("bp_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
    end
    wait_ready(1'b1);
    tick(); lsu_req_valid = 1'b0; lsu_addr = '0; stall_cfg = 0;
    wait_resps(5);
    check("bp_grant_count", 64'(grant_log.size()), 64'd5);
    if (grant_log.size() == 5) begin
      check("bp_grant_ifu", {63'd0, grant_log[3]}, 64'd0);
      check("bp_grant_lsu", {63'd0, grant_log[4]}, 64'd1);
    end

    // timeout: no response, zero data, sticky bus_err, late rvalid ignored
    tick(); hang = 1'b1;
    issue_ifu(64'h8000_5000);
    wait_resps(6);
    check("to_latency_window",
          {63'd0, (last_resp_cyc - last_acc_cyc >= TO + 2) && (last_resp_cyc - last_acc_cyc <= TO + 3)},
          64'd1);
    sample();
    check("to_bus_err", {63'd0, bus_err}, 64'd1);
    tick(); late_inject = 1'b1;
    sample(); late_inject = 1'b0;
    repeat (4) sample();
    check("late_rvalid_ignored", 64'(resp_count), 64'd6);
    check("late_mem_valid", {63'd0, mem_valid}, 64'd0);
    hang = 1'b0;
    issue_ifu(64'h8000_6000);
    wait_resps(7);
    check("bus_err_sticky", {63'd0, bus_err}, 64'd1);

    // mid-transaction reset during RESP
    tick(); hang = 1'b1;
    issue_ifu(64'h8000_7000);
    tick();
    ifu_req_valid = 1'b1; ifu_addr = 64'h8000_9000;
    lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_8000;
    rst_n = 1'b0;
    #1;
    check("mrst_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("mrst_mem_fields", mem_addr | mem_wdata | {55'd0, mem_we, mem_wmask}, 64'd0);
    check("mrst_resp", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    check("mrst_resp_data", ifu_resp_data | lsu_resp_data, 64'd0);
    check("mrst_bus_err", {63'd0, bus_err}, 64'd0);
    check("mrst_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
    hang = 1'b0;
    base = resp_count;
    repeat (3) tick();
    rst_n = 1'b1;

    // conflict round-robin with both requesters held valid
    wait_resps(base + 4);
    tick(); ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    for (int i = 0; i < 50 && sb.size() > 0; i++) sample();
    repeat (3) sample();
    check("rr_sb_drained", 64'(sb.size()), 64'd0);
    check("rr_resp_count", 64'(resp_count - base), 64'(grant_log.size()));
    if (grant_log.size() >= 4) begin
      check("rr_grant0_lsu", {63'd0, grant_log[0]}, 64'd1);
      check("rr_grant1_ifu", {63'd0, grant_log[1]}, 64'd0);
      check("rr_grant2_lsu", {63'd0, grant_log[2]}, 64'd1);
      check("rr_grant3_ifu", {63'd0, grant_log[3]}, 64'd0);
    end else begin
      check("rr_grant_count", 64'(grant_log.size()), 64'd4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single physical memory port between instruction fetch (IFU) and load/store (LSU).
- Each requester has a valid/ready request channel and a response pulse.
- Exactly one transaction is outstanding at a time, with round-robin arbitration on conflict.
- A response timeout guards against a hung memory model.
- Sits between IFU/LSU and the DPI-backed memory wrapper.

## Interface

Parameters:
- AW, 64, address width
- DW, 64, data width
- TIMEOUT, 255, max cycles waiting for a response before forced completion (1..65535)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_addr  in  AW  fetch address
- ifu_resp_valid  out  1  one-cycle fetch response pulse
- ifu_resp_data  out  DW  fetched data
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  load/store request accepted this cycle
- lsu_we  in  1  1 = store, 0 = load
- lsu_addr  in  AW  load/store address
- lsu_wdata  in  DW  store data
- lsu_wmask  in  DW/8  store byte mask
- lsu_resp_valid  out  1  one-cycle load data / store ack pulse
- lsu_resp_data  out  DW  load data; 0 for stores
- mem_valid  out  1  downstream request valid
- mem_ready  in  1  downstream accepts request
- mem_we, mem_addr, mem_wdata, mem_wmask  out  1/AW/DW/DW/8  latched request fields
- mem_rvalid  in  1  downstream response (reads and writes)
- mem_rdata  in  DW  downstream read data
- bus_err  out  1  sticky: a timeout occurred

## Operation

- FSM states: IDLE, REQ, RESP.
- **IDLE:**
  - Winner selection when one or both requesters are valid:
    - Only one valid: it wins.
    - Both valid: the one not granted last wins.
  - `last_grant` resets to IFU, so the LSU wins the first conflict.
  - The winner's `*_req_ready` is 1 combinationally in the same cycle.
  - Its fields are latched into mem_* registers, `owner` and `last_grant` are updated, and the FSM goes to REQ.
  - For IFU requests, `mem_we=0` and `mem_wmask=0`.
  - `*_req_ready` is 0 in every state other than IDLE.
- **REQ:**
  - `mem_valid=1`; latched fields are held stable.
  - On `mem_ready=1`, go to RESP and clear the wait counter.
- **RESP:**
  - Counter increments each cycle.
  - On `mem_rvalid=1`:
    - Pulse the owner's `resp_valid`, with data = `mem_rdata` for loads/fetches and 0 for stores.
    - Go to IDLE.
  - If the counter reaches TIMEOUT without `rvalid`:
    - Pulse the owner's `resp_valid` with data 0.
    - Set `bus_err`, which stays 1 until reset.
    - Go to IDLE.
- `mem_rvalid` is ignored outside RESP, including late responses after a timeout.
- The non-owner's `resp_valid` is always 0.
- Reset (asynchronous, any state):
  - FSM goes to IDLE; `owner` and `last_grant` go to IFU; counter and `bus_err` go to 0.
  - Any in-flight transaction is dropped with no response.

## Timing

- Reset values: all outputs 0, except `*_req_ready`, which follows IDLE arbitration once `rst_n` deasserts.
- Response pulse outputs and `mem_*` are registered.
- Best-case latency:
  - Accept at cycle N; `mem_valid` at N+1.
  - `mem_ready` at N+1; `mem_rvalid` at N+2.
  - `resp_valid` at N+3; next accept possible at N+3.
- `resp_valid` is registered from `mem_rvalid`: one cycle after `mem_rvalid`.
- Throughput: at most one transaction per 3 cycles.
- The downstream must not assert `mem_rvalid` in the same cycle as `mem_ready`; such a response is ignored.
- Timeout: `resp_valid` and `bus_err` rise one cycle after the RESP cycle in which the counter reaches TIMEOUT.
- A requester may deassert `valid` before `ready` without side effects.
- Requester fields are sampled only in the accepting cycle.

## Test plan

- **Single fetch:**
  - Stimulus: `ifu_addr=0x8000_0000` valid; memory ready immediately, returns `0x0000_0013_0000_0093` next cycle.
  - Required: `ifu_resp_valid` one pulse at N+3 with that data; no `lsu_resp_valid`.
- **Store ack:**
  - Stimulus: LSU store, `addr=0x8000_1000`, `wdata=0xDEAD_BEEF`, `wmask=0x0F`.
  - Required: `mem_we=1` with fields exact while `mem_valid`; `lsu_resp_data=0` on the ack pulse.
- **Conflict round-robin:**
  - Stimulus: IFU and LSU both held valid from reset for 4 transactions.
  - Required: grant order LSU, IFU, LSU, IFU; each response goes only to its owner.
- **Backpressure:**
  - Stimulus: `mem_ready` held 0 for 5 cycles.
  - Required: `mem_*` stable; both `req_ready` stay 0; the other requester's valid remains pending.
- **Timeout:**
  - Stimulus: TIMEOUT=4, `mem_rvalid` never asserted.
  - Required: owner's `resp_valid` pulses with data 0; `bus_err=1` persists; a late `mem_rvalid` is ignored.
- **Mid-transaction reset:**
  - Stimulus: `rst_n` low during RESP.
  - Required: all outputs 0 immediately; no response pulse after release; next conflict is granted to LSU.
